centroid_tracker: RTL

Parametrised per-frame object locator. Qualifies pixels of the frame-difference stream against a runtime threshold and accumulates count and x/y coordinate sums. At end of frame it computes the centroid with a multi-cycle sequential divider and presents the result on a valid/ready output. It sits between the frame-difference stage and the overlay/tracking logic, and adds a minimum-size reject, overrun detection and an optional bounding box.

---
 rtl/centroid_pkg.sv | 50 +++++
 rtl/centroid_tracker_if.sv | 52 +++++
 rtl/seq_divider.sv | 97 +++++++++
 rtl/centroid_tracker.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/centroid_pkg.sv
// centroid_pkg: shared types and width derivations for the centroid tracker.
//   state_e         - tracker FSM states (idle, dividing, holding a result)
//   OVR_WIDTH       - width of the saturating overrun counter
//   clog2()         - ceiling log2 usable in constant expressions
//   cnt_width()     - pixel counter width for a given frame size
//   sum_width()     - coordinate accumulator width
//   BOX_* indices   - slot order of the packed bounding-box vectors
package centroid_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StDivide,
        StHold
    } state_e;

    localparam int unsigned OVR_WIDTH = 8;

    // Bounding-box slots: {y_max, y_min, x_max, x_min}
    localparam int unsigned BOX_XMIN = 0;
    localparam int unsigned BOX_XMAX = 1;
    localparam int unsigned BOX_YMIN = 2;
    localparam int unsigned BOX_YMAX = 3;

    function automatic int unsigned clog2(input longint unsigned value);
        int unsigned       res;
        longint unsigned   pow;
        res = 0;
        pow = 1;
        while (pow < value) begin
            pow = pow << 1;
            res = res + 1;
        end
        return res;
    endfunction

    // Enough bits to count every pixel of a (x_max+1) x (y_max+1) frame.
    function automatic int unsigned cnt_width(input int unsigned x_max, input int unsigned y_max);
        longint unsigned xs;
        longint unsigned ys;
        xs = 64'(x_max) + 64'd1;
        ys = 64'(y_max) + 64'd1;
        return clog2(xs * ys + 64'd1);
    endfunction

    // Sum of up to 2^cnt_w coordinates of coord_w bits each cannot overflow.
    function automatic int unsigned sum_width(input int unsigned cnt_w, input int unsigned coord_w);
        return cnt_w + coord_w;
    endfunction

endpackage

// File: rtl/centroid_tracker_if.sv
// centroid_tracker_if: pixel stream in, centroid result out.
//   enable, vga_x, vga_y, delta_frame, threshold - pixel stream and run control
//   out_valid/out_ready                          - result handshake
//   x_position, y_position, pixel_count,
//   object_found, overrun_count                  - result payload
//   x_min, x_max, y_min, y_max                   - bounding box (CENTROID_BBOX_EN only)
// master: pixel source / result consumer.  slave: the tracker.
interface centroid_tracker_if #(
    parameter int unsigned COORD_WIDTH = 11,
    parameter int unsigned COLOR_WIDTH = 10,
    parameter int unsigned CNT_WIDTH   = 19
);
    import centroid_pkg::*;

    logic                   enable;
    logic [COORD_WIDTH-1:0] vga_x;
    logic [COORD_WIDTH-1:0] vga_y;
    logic [COLOR_WIDTH-1:0] delta_frame;
    logic [COLOR_WIDTH-1:0] threshold;
    logic                   out_valid;
    logic                   out_ready;
    logic [COORD_WIDTH-1:0] x_position;
    logic [COORD_WIDTH-1:0] y_position;
    logic [CNT_WIDTH-1:0]   pixel_count;
    logic                   object_found;
    logic [OVR_WIDTH-1:0]   overrun_count;
`ifdef CENTROID_BBOX_EN
    logic [COORD_WIDTH-1:0] x_min;
    logic [COORD_WIDTH-1:0] x_max;
    logic [COORD_WIDTH-1:0] y_min;
    logic [COORD_WIDTH-1:0] y_max;
`endif

    modport master (
        output enable, vga_x, vga_y, delta_frame, threshold, out_ready,
        input  out_valid, x_position, y_position, pixel_count, object_found, overrun_count
`ifdef CENTROID_BBOX_EN
        ,
        input  x_min, x_max, y_min, y_max
`endif
    );

    modport slave (
        input  enable, vga_x, vga_y, delta_frame, threshold, out_ready,
        output out_valid, x_position, y_position, pixel_count, object_found, overrun_count
`ifdef CENTROID_BBOX_EN
        ,
        output x_min, x_max, y_min, y_max
`endif
    );

endinterface

// File: rtl/seq_divider.sv
// seq_divider: restoring unsigned divider, one quotient bit per cycle.
//   clk, aresetn         - clock, asynchronous active-low reset
//   clr_i                - synchronous abort, returns to idle
//   start_i              - load dividend_i/divisor_i (ignored while busy)
//   busy_o               - iteration in progress
//   done_o               - final iteration this cycle; quotient_o valid now
//   quotient_o           - quotient (combinational, meaningful with done_o)
// WIDTH iterations follow the start edge; done_o is high during the last one so the
// caller can capture the result on the same edge that retires it.
module seq_divider #(
    parameter int unsigned WIDTH = 30
) (
    input  logic             clk,
    input  logic             aresetn,
    input  logic             clr_i,
    input  logic             start_i,
    input  logic [WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] quotient_o
);
    localparam int unsigned           IterWidth = $clog2(WIDTH + 1);
    localparam logic [IterWidth-1:0]  LastIter  = IterWidth'(WIDTH - 1);

    logic                 busy_q, busy_d;
    logic [IterWidth-1:0] iter_q, iter_d;
    logic [WIDTH-1:0]     quo_q, quo_d;
    logic [WIDTH-1:0]     rem_q, rem_d;
    logic [WIDTH-1:0]     dvs_q, dvs_d;

    logic [WIDTH:0]       shifted;
    logic [WIDTH+1:0]     trial;
    logic [WIDTH-1:0]     rem_step;
    logic [WIDTH-1:0]     quo_step;
    logic                 unused_bits;

    // Dividend shifts out of quo_q MSB-first while quotient bits shift in at the LSB.
    always_comb begin
        shifted  = {rem_q, quo_q[WIDTH-1]};
        trial    = {1'b0, shifted} - {2'b00, dvs_q};
        quo_step = {quo_q[WIDTH-2:0], ~trial[WIDTH+1]};
        // A negative trial means shifted < divisor, so its top bit is already zero.
        rem_step = trial[WIDTH+1] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
    end

    assign unused_bits = ^{trial[WIDTH], shifted[WIDTH]};

    assign busy_o     = busy_q;
    assign done_o     = busy_q && (iter_q == LastIter);
    assign quotient_o = quo_step;

    always_comb begin
        busy_d = busy_q;
        iter_d = iter_q;
        quo_d  = quo_q;
        rem_d  = rem_q;
        dvs_d  = dvs_q;
        if (clr_i) begin
            busy_d = 1'b0;
            iter_d = '0;
            quo_d  = '0;
            rem_d  = '0;
            dvs_d  = '0;
        end else if (busy_q) begin
            quo_d  = quo_step;
            rem_d  = rem_step;
            iter_d = iter_q + 1'b1;
            if (done_o) begin
                busy_d = 1'b0;
            end
        end else if (start_i) begin
            busy_d = 1'b1;
            iter_d = '0;
            quo_d  = dividend_i;
            rem_d  = '0;
            dvs_d  = divisor_i;
        end
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            busy_q <= 1'b0;
            iter_q <= '0;
            quo_q  <= '0;
            rem_q  <= '0;
            dvs_q  <= '0;
        end else begin
            busy_q <= busy_d;
            iter_q <= iter_d;
            quo_q  <= quo_d;
            rem_q  <= rem_d;
            dvs_q  <= dvs_d;
        end
    end

endmodule

// File: rtl/centroid_tracker.sv
// centroid_tracker: per-frame object locator on the frame-difference stream.
//   clk, aresetn - clock, asynchronous active-low reset
//   bus          - centroid_tracker_if.slave: pixel stream in, centroid result out
// Pixels with delta_frame >= threshold are counted and their coordinates summed. The
// end-of-frame pixel (FRAME_X_MAX, FRAME_Y_MAX) snapshots the sums into two dividers
// (x and y share the count divisor) and the result is held on out_valid/out_ready.
// Frames with fewer than MIN_COUNT pixels skip the divide and report object_found = 0.
// An end of frame while a result is pending or being computed is dropped and counted.
// Optional: define CENTROID_BBOX_EN to track and report the qualified-pixel bounding box.
module centroid_tracker #(
    parameter int unsigned COORD_WIDTH = 11,
    parameter int unsigned COLOR_WIDTH = 10,
    parameter int unsigned FRAME_X_MAX = 640,
    parameter int unsigned FRAME_Y_MAX = 480,
    parameter int unsigned MIN_COUNT   = 16
) (
    input logic               clk,
    input logic               aresetn,
    centroid_tracker_if.slave bus
);
    import centroid_pkg::*;

    localparam int unsigned            CNT_WIDTH = cnt_width(FRAME_X_MAX, FRAME_Y_MAX);
    localparam int unsigned            SUM_WIDTH = sum_width(CNT_WIDTH, COORD_WIDTH);
    localparam logic [COORD_WIDTH-1:0] EofX      = COORD_WIDTH'(FRAME_X_MAX);
    localparam logic [COORD_WIDTH-1:0] EofY      = COORD_WIDTH'(FRAME_Y_MAX);
    localparam logic [CNT_WIDTH-1:0]   MinCnt    = CNT_WIDTH'(MIN_COUNT);

    state_e                 state_q, state_d;
    logic                   enable, eof, qual, go_div;
    logic                   div_start, div_load, sc_load, out_valid;
    logic                   x_done, y_done;
    logic [SUM_WIDTH-1:0]   x_quo, y_quo;
    logic [COLOR_WIDTH-1:0] delta, thresh;

    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d, snap_cnt_q, snap_cnt_d, pix_q, pix_d;
    logic [SUM_WIDTH-1:0]   xsum_q, xsum_d, ysum_q, ysum_d;
    logic [COORD_WIDTH-1:0] xpos_q, xpos_d, ypos_q, ypos_d;
    logic                   found_q, found_d;
    logic [OVR_WIDTH-1:0]   ovr_q, ovr_d;
    logic                   unused_quo;

    assign enable = bus.enable;
    assign delta  = bus.delta_frame;
    assign thresh = bus.threshold;
    assign eof    = enable && (bus.vga_x == EofX) && (bus.vga_y == EofY);
    assign qual   = enable && !eof && (delta >= thresh);
    // Zero pixels must never reach the divider even if MIN_COUNT is 0.
    assign go_div = (cnt_q >= MinCnt) && (cnt_q != '0);

    // State register
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state
    always_comb begin
        state_d = state_q;
        if (!enable) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle:   if (eof) state_d = go_div ? StDivide : StHold;
                StDivide: if (x_done && y_done) state_d = StHold;
                StHold:   if (bus.out_ready) state_d = StIdle;
                default:  state_d = StIdle;
            endcase
        end
    end

    // FSM outputs
    always_comb begin
        out_valid = (state_q == StHold);
        div_start = eof && (state_q == StIdle) && go_div;
        sc_load   = eof && (state_q == StIdle) && !go_div;
        div_load  = enable && (state_q == StDivide) && x_done && y_done;
    end

    seq_divider #(
        .WIDTH (SUM_WIDTH)
    ) u_div_x (
        .clk        (clk),
        .aresetn    (aresetn),
        .clr_i      (!enable),
        .start_i    (div_start),
        .dividend_i (xsum_q),
        .divisor_i  (SUM_WIDTH'(cnt_q)),
        .busy_o     (),
        .done_o     (x_done),
        .quotient_o (x_quo)
    );

    seq_divider #(
        .WIDTH (SUM_WIDTH)
    ) u_div_y (
        .clk        (clk),
        .aresetn    (aresetn),
        .clr_i      (!enable),
        .start_i    (div_start),
        .dividend_i (ysum_q),
        .divisor_i  (SUM_WIDTH'(cnt_q)),
        .busy_o     (),
        .done_o     (y_done),
        .quotient_o (y_quo)
    );

    // Centroid of in-frame pixels always fits in COORD_WIDTH bits.
    assign unused_quo = ^{x_quo[SUM_WIDTH-1:COORD_WIDTH], y_quo[SUM_WIDTH-1:COORD_WIDTH]};

`ifdef CENTROID_BBOX_EN
    localparam logic [3:0][COORD_WIDTH-1:0] RunBoxInit =
        {{COORD_WIDTH{1'b0}}, {COORD_WIDTH{1'b1}}, {COORD_WIDTH{1'b0}}, {COORD_WIDTH{1'b1}}};

    logic [3:0][COORD_WIDTH-1:0] run_box_q, run_box_d;
    logic [3:0][COORD_WIDTH-1:0] snap_box_q, snap_box_d;
    logic [3:0][COORD_WIDTH-1:0] box_q, box_d;

    always_comb begin
        run_box_d  = run_box_q;
        snap_box_d = snap_box_q;
        box_d      = box_q;
        if (!enable) begin
            run_box_d  = RunBoxInit;
            snap_box_d = '0;
            box_d      = '0;
        end else begin
            if (eof) begin
                run_box_d = RunBoxInit;
                if (state_q == StIdle) snap_box_d = run_box_q;
            end else if (qual) begin
                if (bus.vga_x < run_box_q[BOX_XMIN]) run_box_d[BOX_XMIN] = bus.vga_x;
                if (bus.vga_x > run_box_q[BOX_XMAX]) run_box_d[BOX_XMAX] = bus.vga_x;
                if (bus.vga_y < run_box_q[BOX_YMIN]) run_box_d[BOX_YMIN] = bus.vga_y;
                if (bus.vga_y > run_box_q[BOX_YMAX]) run_box_d[BOX_YMAX] = bus.vga_y;
            end
            if (sc_load) begin
                box_d = '0;
            end else if (div_load) begin
                box_d = snap_box_q;
            end
        end
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            run_box_q  <= RunBoxInit;
            snap_box_q <= '0;
            box_q      <= '0;
        end else begin
            run_box_q  <= run_box_d;
            snap_box_q <= snap_box_d;
            box_q      <= box_d;
        end
    end

    assign bus.x_min = box_q[BOX_XMIN];
    assign bus.x_max = box_q[BOX_XMAX];
    assign bus.y_min = box_q[BOX_YMIN];
    assign bus.y_max = box_q[BOX_YMAX];
`endif

    always_comb begin
        cnt_d      = cnt_q;
        xsum_d     = xsum_q;
        ysum_d     = ysum_q;
        snap_cnt_d = snap_cnt_q;
        ovr_d      = ovr_q;
        pix_d      = pix_q;
        xpos_d     = xpos_q;
        ypos_d     = ypos_q;
        found_d    = found_q;
        if (!enable) begin
            cnt_d      = '0;
            xsum_d     = '0;
            ysum_d     = '0;
            snap_cnt_d = '0;
            ovr_d      = '0;
            pix_d      = '0;
            xpos_d     = '0;
            ypos_d     = '0;
            found_d    = 1'b0;
        end else begin
            if (eof) begin
                cnt_d  = '0;
                xsum_d = '0;
                ysum_d = '0;
                if (state_q == StIdle) begin
                    snap_cnt_d = cnt_q;
                end else if (ovr_q != '1) begin
                    ovr_d = ovr_q + 1'b1;
                end
            end else if (qual) begin
                cnt_d  = cnt_q + 1'b1;
                xsum_d = xsum_q + SUM_WIDTH'(bus.vga_x);
                ysum_d = ysum_q + SUM_WIDTH'(bus.vga_y);
            end
            // Short-circuit report keeps the previous positions.
            if (sc_load) begin
                pix_d   = cnt_q;
                found_d = 1'b0;
            end else if (div_load) begin
                pix_d   = snap_cnt_q;
                xpos_d  = x_quo[COORD_WIDTH-1:0];
                ypos_d  = y_quo[COORD_WIDTH-1:0];
                found_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            cnt_q      <= '0;
            xsum_q     <= '0;
            ysum_q     <= '0;
            snap_cnt_q <= '0;
            ovr_q      <= '0;
            pix_q      <= '0;
            xpos_q     <= '0;
            ypos_q     <= '0;
            found_q    <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            xsum_q     <= xsum_d;
            ysum_q     <= ysum_d;
            snap_cnt_q <= snap_cnt_d;
            ovr_q      <= ovr_d;
            pix_q      <= pix_d;
            xpos_q     <= xpos_d;
            ypos_q     <= ypos_d;
            found_q    <= found_d;
        end
    end

    assign bus.out_valid     = out_valid;
    assign bus.x_position    = xpos_q;
    assign bus.y_position    = ypos_q;
    assign bus.pixel_count   = pix_q;
    assign bus.object_found  = found_q;
    assign bus.overrun_count = ovr_q;

endmodule
